matmul_apb_slave: RTL and testbench
===================================

MATMUL_APB_SLAVE -- requirements
Module: matmul_apb_slave

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, meaning APB data width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning operand element width.
REQ-003 SHALL have parameter MAX_DIM, default BUS_WIDTH/DATA_WIDTH, meaning matrix dimension and pstrb width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 16, meaning APB address width.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port psel_i, input, 1, APB select.
REQ-008 SHALL have port penable_i, input, 1, APB enable.
REQ-009 SHALL have port pwrite_i, input, 1, 1=write, 0=read.
REQ-010 SHALL have port pstrb_i, input, MAX_DIM, byte-lane write strobes.
REQ-011 SHALL have port pwdata_i, input, BUS_WIDTH, write data.
REQ-012 SHALL have port paddr_i, input, ADDR_WIDTH, address; [4:0] region, [5+:$clog2(MAX_DIM*MAX_DIM)] index.
REQ-013 SHALL have port pready_o, output, 1, transfer complete.
REQ-014 SHALL have port pslverr_o, output, 1, transfer error, valid with pready_o.
REQ-015 SHALL have port prdata_o, output, BUS_WIDTH, read data, valid with pready_o.
REQ-016 SHALL have port busy_i, input, 1, matmul core computing.
REQ-017 SHALL have port flags_i, input, BUS_WIDTH, core status word.
REQ-018 SHALL have port start_o, output, 1, one-cycle start pulse to core.
REQ-019 SHALL have port ctrl_o, output, BUS_WIDTH, stored CONTROL word, bit0 always 0.
REQ-020 SHALL have port operand_a_o / operand_b_o, output, MAX_DIM*BUS_WIDTH each, row r at [r*BUS_WIDTH+:BUS_WIDTH].
REQ-021 SHALL have port sp_re_o, output, 1, scratchpad read enable; sp_addr_o, output, $clog2(MAX_DIM*MAX_DIM), entry; sp_rdata_i, input, BUS_WIDTH, data valid the cycle after sp_re_o.

Function
REQ-022 Map paddr_i[4:0]: 00000 CONTROL, 00100 OPERAND_A, 01000 OPERAND_B, 01100 FLAGS, 10000 SP; any other value SHALL be an error.
REQ-023 FSM states IDLE, SP_RD, RESP; IDLE -> (psel_i & !penable_i sampled) -> SP_RD if SP read else RESP.
REQ-024 SP_RD: sp_re_o=1, sp_addr_o=paddr index for one cycle; next edge captures sp_rdata_i into prdata_o, -> RESP (one wait state).
REQ-025 RESP: pready_o=1 for exactly one cycle; non-SP transfers SHALL therefore complete on the second edge after setup (zero wait states).
REQ-026 RESP -> IDLE always; back-to-back setup in the completion cycle SHALL be accepted from IDLE next cycle.
REQ-027 Writes SHALL take effect at the RESP completion edge only when psel_i & penable_i & !error.
REQ-028 OPERAND_A/B write: row = index mod MAX_DIM; only byte lanes with pstrb_i[k]=1 updated; index >= MAX_DIM is an error.
REQ-029 CONTROL write: store pwdata_i[BUS_WIDTH-1:1]; if pwdata_i[0]=1, start_o=1 the cycle after completion edge, self-clearing.
REQ-030 Reads: CONTROL returns ctrl_o; OPERAND returns addressed row; FLAGS returns flags_i sampled at setup edge; SP returns sp_rdata_i.
REQ-031 Error (pslverr_o=1, prdata_o=0, no state change) on: unmapped region, paddr_i[1:0]!=0, write to FLAGS or SP, write to CONTROL/OPERAND while busy_i=1.
REQ-032 pready_o, pslverr_o, prdata_o SHALL be 0 in IDLE and SP_RD.
REQ-033 psel_i deasserted in SP_RD or RESP SHALL abort: return to IDLE, no write, no start_o.

Reset
REQ-034 rst_ni=0 SHALL immediately force IDLE and zero pready_o, pslverr_o, prdata_o, start_o, ctrl_o, operands, sp_re_o, sp_addr_o.
REQ-035 Reset mid-transfer SHALL discard the transfer; no register modified.

Verification
REQ-036 Write OPERAND_A idx 2, pwdata 0x11223344, pstrb 0101 -> row2 = 0x00220044, pready 1 cycle, pslverr 0.
REQ-037 Write CONTROL 0x5 with busy_i=0 -> ctrl_o=0x4, start_o high exactly one cycle; repeat with busy_i=1 -> pslverr 1, ctrl_o unchanged, no start_o.
REQ-038 Read SP idx 7, sp_rdata_i=0xDEADBEEF -> sp_re_o/sp_addr_o=7 one cycle, pready one cycle later with prdata 0xDEADBEEF.
REQ-039 Write FLAGS, write SP, access paddr 0x14, access paddr 0x06 -> each pslverr 1, prdata 0, no state change.
REQ-040 Assert rst_ni=0 during RESP of CONTROL write 0x3 -> outputs zero immediately, ctrl_o stays 0, no start_o.

Source files
------------

// File: rtl/matmul_apb_slave_if.sv
// APB bus bundle for the matmul register slave.
// Signals: psel/penable/pwrite/pstrb/pwdata/paddr in, pready/pslverr/prdata out.
interface matmul_apb_slave_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int STRB_WIDTH = 4,
  parameter int ADDR_WIDTH = 16
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [BUS_WIDTH-1:0]  pwdata;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pready;
  logic                  pslverr;
  logic [BUS_WIDTH-1:0]  prdata;

  modport master (
    output psel, penable, pwrite, pstrb, pwdata, paddr,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, pstrb, pwdata, paddr,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/matmul_apb_slave.sv
// APB register slave for a matmul core: CONTROL, operand rows, FLAGS, scratchpad.
// Ports: APB slave (psel/penable/...), core side busy/flags/start/ctrl/operands, scratchpad read.
module matmul_apb_slave #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int ADDR_WIDTH = 16,
  localparam int IDX_W     = $clog2(MAX_DIM * MAX_DIM)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [MAX_DIM-1:0]           pstrb_i,
  input  logic [BUS_WIDTH-1:0]         pwdata_i,
  input  logic [ADDR_WIDTH-1:0]        paddr_i,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic [BUS_WIDTH-1:0]         prdata_o,
  input  logic                         busy_i,
  input  logic [BUS_WIDTH-1:0]         flags_i,
  output logic                         start_o,
  output logic [BUS_WIDTH-1:0]         ctrl_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] operand_a_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] operand_b_o,
  output logic                         sp_re_o,
  output logic [IDX_W-1:0]             sp_addr_o,
  input  logic [BUS_WIDTH-1:0]         sp_rdata_i
);

  localparam int ROW_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [IDX_W-1:0] MAXD = IDX_W'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, SP_RD, RESP} state_t;

  state_t state, state_nx;

  logic [4:0]           reg_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 write_q;
  logic [BUS_WIDTH-1:0] flags_q;
  logic [BUS_WIDTH-1:0] sp_q;
  logic [BUS_WIDTH-1:0] opa [MAX_DIM];
  logic [BUS_WIDTH-1:0] opb [MAX_DIM];

  logic                 setup;
  logic                 is_ctrl, is_a, is_b, is_flg, is_sp;
  logic                 err;
  logic                 commit;
  logic [ROW_W-1:0]     row;
  logic [BUS_WIDTH-1:0] rd_data;

  logic unused;
  assign unused = ^paddr_i[ADDR_WIDTH-1:5+IDX_W];

  assign setup = (state == IDLE) && psel_i && !penable_i;

  assign is_ctrl = reg_q == 5'h00;
  assign is_a    = reg_q == 5'h04;
  assign is_b    = reg_q == 5'h08;
  assign is_flg  = reg_q == 5'h0C;
  assign is_sp   = reg_q == 5'h10;
  assign row     = idx_q[ROW_W-1:0];

  // Misaligned addresses fall out as unmapped regions.
  assign err = !(is_ctrl | is_a | is_b | is_flg | is_sp)
             | (write_q & (is_flg | is_sp))
             | (write_q & busy_i & (is_ctrl | is_a | is_b))
             | (write_q & (is_a | is_b) & (idx_q >= MAXD));

  // Live bus qualifiers at the completion edge; a dropped psel aborts.
  assign commit = (state == RESP) && psel_i && penable_i
                  && write_q && !err;

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      is_ctrl: rd_data = ctrl_o;
      is_a:    rd_data = opa[row];
      is_b:    rd_data = opb[row];
      is_flg:  rd_data = flags_q;
      is_sp:   rd_data = sp_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (setup) begin
          if (!pwrite_i && paddr_i[4:0] == 5'h10) state_nx = SP_RD;
          else                                    state_nx = RESP;
        end
      end
      SP_RD:   state_nx = psel_i ? RESP : IDLE;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    sp_re_o   = 1'b0;
    sp_addr_o = '0;
    unique case (state)
      SP_RD: begin
        sp_re_o   = 1'b1;
        sp_addr_o = idx_q;
      end
      RESP: begin
        pready_o  = 1'b1;
        pslverr_o = err;
        if (!err && !write_q) prdata_o = rd_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      flags_q <= '0;
      sp_q    <= '0;
    end else begin
      if (setup) begin
        reg_q   <= paddr_i[4:0];
        idx_q   <= paddr_i[5+:IDX_W];
        write_q <= pwrite_i;
        flags_q <= flags_i;
      end
      if (state == SP_RD) sp_q <= sp_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_o <= 1'b0;
      ctrl_o  <= '0;
      for (int r = 0; r < MAX_DIM; r++) begin
        opa[r] <= '0;
        opb[r] <= '0;
      end
    end else begin
      start_o <= commit && is_ctrl && pwdata_i[0];
      if (commit && is_ctrl) ctrl_o <= {pwdata_i[BUS_WIDTH-1:1], 1'b0};
      for (int k = 0; k < MAX_DIM; k++) begin
        if (commit && pstrb_i[k]) begin
          if (is_a) opa[row][k*DATA_WIDTH+:DATA_WIDTH]
              <= pwdata_i[k*DATA_WIDTH+:DATA_WIDTH];
          if (is_b) opb[row][k*DATA_WIDTH+:DATA_WIDTH]
              <= pwdata_i[k*DATA_WIDTH+:DATA_WIDTH];
        end
      end
    end
  end

  for (genvar r = 0; r < MAX_DIM; r++) begin : g_rows
    assign operand_a_o[r*BUS_WIDTH+:BUS_WIDTH] = opa[r];
    assign operand_b_o[r*BUS_WIDTH+:BUS_WIDTH] = opb[r];
  end

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Directed self-checking bench for matmul_apb_slave.
// Drives APB transfers through the bus interface and checks core-side outputs.
module tb_matmul_apb_slave;

  localparam int BW = 32;
  localparam int DW = 8;
  localparam int MD = 4;
  localparam int AW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic busy = 1'b0;
  logic [BW-1:0] flags = '0;
  logic [BW-1:0] sp_rdata = '0;
  logic start;
  logic [BW-1:0] ctrl;
  logic [MD*BW-1:0] opa, opb;
  logic sp_re;
  logic [IW-1:0] sp_addr;

  matmul_apb_slave_if #(.BUS_WIDTH(BW), .STRB_WIDTH(MD), .ADDR_WIDTH(AW)) bus ();

  matmul_apb_slave #(
    .BUS_WIDTH(BW), .DATA_WIDTH(DW), .MAX_DIM(MD), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .psel_i(bus.psel), .penable_i(bus.penable), .pwrite_i(bus.pwrite),
    .pstrb_i(bus.pstrb), .pwdata_i(bus.pwdata), .paddr_i(bus.paddr),
    .pready_o(bus.pready), .pslverr_o(bus.pslverr), .prdata_o(bus.prdata),
    .busy_i(busy), .flags_i(flags), .start_o(start), .ctrl_o(ctrl),
    .operand_a_o(opa), .operand_b_o(opb),
    .sp_re_o(sp_re), .sp_addr_o(sp_addr), .sp_rdata_i(sp_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [BW-1:0] r_data;
  logic r_err, r_got, r_sre, r_after, r_st1, r_st2;
  logic [IW-1:0] r_saddr;
  int r_waits;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic xfer(input logic wr, input logic [AW-1:0] addr,
                      input logic [BW-1:0] data, input logic [MD-1:0] strb);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = data; bus.pstrb = strb;
    @(negedge clk);
    bus.penable = 1'b1;
    r_sre = sp_re; r_saddr = sp_addr; r_waits = 0;
    while (!bus.pready && r_waits < 8) begin
      @(negedge clk);
      r_waits++;
    end
    r_got = bus.pready; r_data = bus.prdata; r_err = bus.pslverr;
    @(posedge clk);
    #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    r_after = bus.pready; r_st1 = start;
    @(negedge clk);
    r_st2 = start;
  endtask

  initial begin
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    repeat (2) @(negedge clk);
    chk("rst_pready", bus.pready, 0);
    chk("rst_pslverr", bus.pslverr, 0);
    chk("rst_prdata", bus.prdata, 0);
    chk("rst_start", start, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_opa", opa, 0);
    chk("rst_spre", sp_re, 0);
    rst_ni = 1'b1;

    // OPERAND_A idx2, lanes 0 and 2 only
    xfer(1, 16'h0044, 32'h11223344, 4'b0101);
    chk("opa2_ready", r_got, 1);
    chk("opa2_waits", r_waits, 0);
    chk("opa2_err", r_err, 0);
    chk("opa2_once", r_after, 0);
    chk("opa2_row", opa[2*BW+:BW], 32'h00220044);
    xfer(0, 16'h0044, 0, 0);
    chk("opa2_rd", r_data, 32'h00220044);

    // OPERAND_B idx1 full then top lane only
    xfer(1, 16'h0028, 32'hAABBCCDD, 4'b1111);
    chk("opb1_full", opb[1*BW+:BW], 32'hAABBCCDD);
    xfer(1, 16'h0028, 32'h99000000, 4'b1000);
    chk("opb1_lane3", opb[1*BW+:BW], 32'h99BBCCDD);

    // operand index >= MAX_DIM
    xfer(1, 16'h00A4, 32'hFFFFFFFF, 4'b1111);
    chk("opa5_err", r_err, 1);
    chk("opa5_row1", opa[1*BW+:BW], 0);

    // CONTROL with start bit
    xfer(1, 16'h0000, 32'h5, 4'b1111);
    chk("ctl_err", r_err, 0);
    chk("ctl_val", ctrl, 32'h4);
    chk("ctl_st1", r_st1, 1);
    chk("ctl_st2", r_st2, 0);
    xfer(0, 16'h0000, 0, 0);
    chk("ctl_rd", r_data, 32'h4);

    busy = 1'b1;
    xfer(1, 16'h0000, 32'h7, 4'b1111);
    chk("ctlb_err", r_err, 1);
    chk("ctlb_val", ctrl, 32'h4);
    chk("ctlb_st", r_st1, 0);
    xfer(1, 16'h0004, 32'h12345678, 4'b1111);
    chk("opab_err", r_err, 1);
    chk("opab_row0", opa[0+:BW], 0);
    busy = 1'b0;

    // FLAGS read
    flags = 32'h12345678;
    xfer(0, 16'h000C, 0, 0);
    chk("flg_rd", r_data, 32'h12345678);
    chk("flg_err", r_err, 0);

    // SP read idx7
    sp_rdata = 32'hDEADBEEF;
    xfer(0, 16'h00F0, 0, 0);
    chk("sp_re", r_sre, 1);
    chk("sp_addr", r_saddr, 7);
    chk("sp_waits", r_waits, 1);
    chk("sp_data", r_data, 32'hDEADBEEF);
    chk("sp_err", r_err, 0);

    // error cases
    xfer(1, 16'h000C, 32'hFFFFFFFF, 4'b1111);
    chk("wflg_err", r_err, 1);
    chk("wflg_rd", r_data, 0);
    xfer(1, 16'h0010, 32'hFFFFFFFF, 4'b1111);
    chk("wsp_err", r_err, 1);
    xfer(0, 16'h0014, 0, 0);
    chk("a14_err", r_err, 1);
    chk("a14_rd", r_data, 0);
    xfer(0, 16'h0006, 0, 0);
    chk("a06_err", r_err, 1);
    chk("a06_rd", r_data, 0);
    xfer(1, 16'h0006, 32'hFF, 4'b1111);
    chk("wa06_err", r_err, 1);
    chk("err_ctrl", ctrl, 32'h4);

    // reset during RESP of CONTROL write 0x3
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h0000; bus.pwdata = 32'h3; bus.pstrb = 4'hF;
    @(negedge clk);
    bus.penable = 1'b1;
    chk("rr_resp", bus.pready, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rr_pready", bus.pready, 0);
    chk("rr_ctrl", ctrl, 0);
    chk("rr_opa2", opa[2*BW+:BW], 0);
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rr_start1", start, 0);
    chk("rr_ctrl1", ctrl, 0);
    @(negedge clk);
    chk("rr_start2", start, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
